free_tag_pool: RTL
==================

Name: free_tag_pool

Overview:
Physical-tag free list for the rename stage. It hands out free physical register tags to rename, one per cycle, using a request/grant handshake. It reclaims up to two tags per cycle from the ReorderBuffer retire ports (freed_tag_1/freed_tag_2). Tag 0 means "no tag" throughout and is never stored or allocated.

Parameters:
NUM_TAGS, 64, total physical tags; power of two; tags 0..NUM_TAGS-1.
TAG_W, 6, tag width; equals log2(NUM_TAGS).
FIRST_FREE, 32, lowest tag free at reset; tags 1..FIRST_FREE-1 hold the initial architectural mapping; 1 <= FIRST_FREE < NUM_TAGS.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
alloc_req  in  1  rename requests one tag this cycle
alloc_grant  out  1  request honoured this cycle; alloc_tag is consumed at the edge
alloc_tag  out  TAG_W  tag at the head of the pool; 0 when the pool is empty
free_tag_1  in  TAG_W  retired tag from the ROB; 0 = none
free_tag_2  in  TAG_W  second retired tag from the ROB; 0 = none
free_count  out  TAG_W+1  number of tags currently in the pool
empty  out  1  free_count == 0
overflow_err  out  1  sticky: a free was dropped because the pool was full

Behaviour:
- Storage: circular FIFO with NUM_TAGS entries of TAG_W bits. head_ptr and tail_ptr are TAG_W bits and wrap modulo NUM_TAGS. count is TAG_W+1 bits.
- Capacity: NUM_TAGS-1. Tag 0 is never resident.
- Reset (async, any time, including mid-operation):
  - entries 0..NUM_TAGS-FIRST_FREE-1 load tags FIRST_FREE..NUM_TAGS-1 in ascending order;
  - head_ptr=0, tail_ptr=NUM_TAGS-FIRST_FREE, count=NUM_TAGS-FIRST_FREE;
  - overflow_err=0.
  - Outputs during and after reset: free_count=NUM_TAGS-FIRST_FREE, alloc_tag=FIRST_FREE, empty=0, alloc_grant=alloc_req.
- Outputs are combinational from state and inputs:
  - alloc_tag = (count != 0) ? entry[head_ptr] : 0;
  - alloc_grant = alloc_req && (count != 0);
  - empty = (count == 0).
- Allocation: on an edge with alloc_grant=1, head_ptr advances by 1. Rename latches alloc_tag at that same edge, so there is zero-cycle latency.
- Freeing: every nonzero free_tag_n is appended at tail_ptr.
  - If both inputs are nonzero, free_tag_1 is written first, then free_tag_2.
  - If only one is nonzero, it takes the single tail slot. There are no holes.
- No bypass: a tag freed in cycle N can be allocated in cycle N+1 at the earliest, even if the pool is empty in cycle N.
- Simultaneous alloc and free: count_next = count - alloc_grant + nfree_accepted. Head and tail update independently in the same edge.
- Full handling: the grant this cycle does not count toward free space.
  - Space = NUM_TAGS-1-count.
  - Frees are accepted in order (free_tag_1 first) while space remains. The rest are dropped.
  - Any drop sets overflow_err=1, which holds until reset.
- No double-free or range checking beyond the tag-0 filter. Free inputs are trusted to be distinct, valid, currently allocated tags.
- No internal state machine beyond the pointers, count and sticky error flag. The block never stalls the ROB.

Test Plan:
All scenarios use NUM_TAGS=8, TAG_W=3, FIRST_FREE=4.
1. Assert reset, release it, hold idle -> free_count=4, alloc_tag=4, empty=0, overflow_err=0.
2. alloc_req=1 for 5 cycles -> grants tags 4,5,6,7 on cycles 1-4. Cycle 5: alloc_grant=0, alloc_tag=0, empty=1, free_count=0.
3. Pool empty; alloc_req=1 with free_tag_1=3, free_tag_2=5 in the same cycle -> alloc_grant=0 that cycle. Next cycle alloc_tag=3, free_count=2. The following grant gives 5.
4. free_tag_1=0, free_tag_2=6 -> one tag enqueued, free_count increments by 1, and 6 is allocated after all earlier tags (FIFO order).
5. Wrap-around: 20 cycles of simultaneous alloc_req=1 and one free of the tag granted two cycles earlier -> free_count constant; the tags cycle in freed order with no corruption across the pointer wrap.
6. Pool holds 6 tags; free_tag_1=1, free_tag_2=2 -> 1 accepted, 2 dropped, free_count=7, overflow_err=1. The error stays set until reset is asserted mid-cycle, after which the reset state of scenario 1 returns.

Source files
------------

// File: rtl/free_tag_pool.sv
// free_tag_pool: circular FIFO of free physical tags; one allocation and up to two reclaims per cycle.
module free_tag_pool #(
  parameter int NUM_TAGS   = 64,
  parameter int TAG_W      = 6,
  parameter int FIRST_FREE = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic [TAG_W-1:0] free_tag_1,
  input  logic [TAG_W-1:0] free_tag_2,
  output logic [TAG_W:0]   free_count,
  output logic             empty,
  output logic             overflow_err
);
  localparam int CNT0 = NUM_TAGS - FIRST_FREE;
  logic [TAG_W-1:0] mem_q [NUM_TAGS];
  logic [TAG_W-1:0] mem_d [NUM_TAGS];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d, space;
  logic             err_q, err_d, f1v, f2v, acc1, acc2;
  assign alloc_grant  = alloc_req && (count_q != '0);
  assign alloc_tag    = (count_q != '0) ? mem_q[head_q] : '0;
  assign free_count   = count_q;
  assign empty        = (count_q == '0);
  assign overflow_err = err_q;
  // The grant in this cycle does not free a slot for this cycle's reclaims.
  always_comb begin
    space   = (TAG_W+1)'(NUM_TAGS - 1) - count_q;
    f1v     = free_tag_1 != '0;
    f2v     = free_tag_2 != '0;
    acc1    = f1v && (space != '0);
    acc2    = f2v && (space > (TAG_W+1)'(acc1));
    mem_d   = mem_q;
    if (acc1) mem_d[tail_q] = free_tag_1;
    if (acc2) mem_d[tail_q + TAG_W'(acc1)] = free_tag_2;
    head_d  = head_q + TAG_W'(alloc_grant);
    tail_d  = tail_q + TAG_W'(acc1) + TAG_W'(acc2);
    count_d = count_q - (TAG_W+1)'(alloc_grant) + (TAG_W+1)'(acc1) + (TAG_W+1)'(acc2);
    err_d   = err_q || (f1v && !acc1) || (f2v && !acc2);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) mem_q[i] <= (i < CNT0) ? TAG_W'(FIRST_FREE + i) : '0;
      head_q  <= '0;
      tail_q  <= TAG_W'(CNT0);
      count_q <= (TAG_W+1)'(CNT0);
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
endmodule
